// File: rtl/dmem_ctrl_pkg.sv
// Shared constants for the data-memory load/store sequencer:
// word width, RISC-V load/store funct3 codes and the 3-bit FSM encodings.
package dmem_ctrl_pkg;

  localparam int WORD_LEN = 32;

  // funct3 codes for loads/stores
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // sequencer states
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  // funct3 values that no load/store may use, plus unsigned stores
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    return bad || (we && f3[2]);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering for the data port.
// Load path: picks the addressed byte/halfword and sign/zero-extends it.
// Store path: merges the low byte/halfword of the store data into the old word.
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [WORD_LEN-1:0] word,
  input  logic [WORD_LEN-1:0] st_data,
  input  logic [1:0]          offs,
  input  logic [2:0]          funct3,
  output logic [WORD_LEN-1:0] ld_data,
  output logic [WORD_LEN-1:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [4:0]  bit_ofs;

  assign bit_ofs = {offs, 3'b000};

  // extract the addressed lane and extend it to a full word
  always_comb begin
    lane_b = word[bit_ofs +: 8];
    lane_h = offs[1] ? word[31:16] : word[15:0];
    case (funct3)
      LSU_B:   ld_data = {{24{lane_b[7]}}, lane_b};
      LSU_H:   ld_data = {{16{lane_h[15]}}, lane_h};
      LSU_W:   ld_data = word;
      LSU_BU:  ld_data = {24'd0, lane_b};
      LSU_HU:  ld_data = {16'd0, lane_h};
      default: ld_data = 32'd0;
    endcase
  end

  // replace only the addressed lane, keep the rest of the old word
  always_comb begin
    merged = word;
    case (funct3[1:0])
      2'b00: merged[bit_ofs +: 8] = st_data[7:0];
      2'b01: begin
        if (offs[1]) begin
          merged[31:16] = st_data[15:0];
        end else begin
          merged[15:0] = st_data[15:0];
        end
      end
      default: merged = st_data;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store sequencer owning the data port of the word-wide shared memory.
// Sub-word stores are done as read-modify-write; loads are extended.
// Build option: define MISALIGN_TRAP_EN to reject misaligned halfword/word
// accesses with resp_err; otherwise the offending low address bits are
// cleared and the access proceeds aligned.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int AWIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [WORD_LEN-1:0] req_addr,
  input  logic [WORD_LEN-1:0] req_wdata,
  output logic                resp_valid,
  output logic                resp_err,
  output logic [WORD_LEN-1:0] resp_rdata,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic                mem_wen,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata
);

  logic [2:0]          state;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [WORD_LEN-1:0] addr_q;
  logic [WORD_LEN-1:0] wdata_q;
  logic                err_q;

  logic                req_err;
  logic [WORD_LEN-1:0] req_addr_al;
  logic [WORD_LEN-1:0] word_addr;
  logic [WORD_LEN-1:0] load_data;
  logic [WORD_LEN-1:0] merged;

  assign req_ready = (state == ST_IDLE);
  assign word_addr = {addr_q[WORD_LEN-1:AWIDTH], addr_q[AWIDTH-1:2], 2'b00};

  // classify the incoming request and produce the address used for lane selection
  always_comb begin
    req_addr_al = req_addr;
`ifdef MISALIGN_TRAP_EN
    req_err = f3_illegal(req_we, req_funct3) ||
              ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
              ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    req_err = f3_illegal(req_we, req_funct3);
    if (req_funct3[1:0] == 2'b01) begin
      req_addr_al[0] = 1'b0;
    end else if (req_funct3[1:0] == 2'b10) begin
      req_addr_al[1:0] = 2'b00;
    end else begin
      req_addr_al = req_addr;
    end
`endif
  end

  dmem_lane_align u_align (
    .word    (mem_rdata),
    .st_data (wdata_q),
    .offs    (addr_q[1:0]),
    .funct3  (f3_q),
    .ld_data (load_data),
    .merged  (merged)
  );

  // sequencer state, latched request and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      err_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            f3_q       <= req_funct3;
            addr_q     <= req_addr_al;
            wdata_q    <= req_wdata;
            err_q      <= req_err;
            resp_rdata <= 32'd0;
            if (req_err) begin
              state <= ST_RESP;
            end else if (req_we && (req_funct3 == LSU_W)) begin
              state <= ST_WR;
            end else begin
              state <= ST_RD;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RD:   state <= ST_DATA;
        ST_DATA: begin
          if (!we_q) begin
            resp_rdata <= load_data;
          end else begin
            resp_rdata <= 32'd0;
          end
          state <= ST_RESP;
        end
        ST_WR:   state <= ST_RESP;
        ST_RESP: begin
          resp_valid <= 1'b1;
          resp_err   <= err_q;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // memory port decoded from the state register and latched request
  always_comb begin
    mem_addr  = 32'd0;
    mem_wen   = 1'b0;
    mem_wdata = 32'd0;
    case (state)
      ST_RD: mem_addr = word_addr;
      ST_DATA: begin
        mem_addr = word_addr;
        if (we_q) begin
          mem_wen   = 1'b1;
          mem_wdata = merged;
        end else begin
          mem_wen   = 1'b0;
        end
      end
      ST_WR: begin
        mem_addr  = word_addr;
        mem_wen   = 1'b1;
        mem_wdata = wdata_q;
      end
      default: mem_addr = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: a behavioural memory plus a reference model
// that computes each access result from byte arithmetic on a shadow memory.
module tb_dmem_ctrl;

  localparam int AW = 16;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_wen;

  bit [31:0] mem     [0:(1<<(AW-2))-1];
  bit [31:0] ref_mem [0:(1<<(AW-2))-1];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc;
    int          lat;
    int          writes;
    int          widx;
    logic [31:0] wval;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   wen_cnt = 0;
  int   wen_edge = 0;

  dmem_ctrl #(.AWIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous memory, read data one cycle after the address is sampled
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr[AW-1:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[AW-1:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: size/alignment/extension from plain arithmetic
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a_in,
                       input logic [31:0] wd, output exp_t e);
    int          size, off, idx;
    bit          illegal, mis;
    logic [31:0] a;
    logic [63:0] mask, w, v;
    a       = a_in;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
    size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis     = (a % size) != 0;
    e.err   = illegal || (TRAP && mis);
    if (!TRAP) a = a - (a % size);
    idx     = int'(a[AW-1:2]);
    off     = int'(a % 4);
    mask    = (64'd1 << (8 * size)) - 64'd1;
    w       = {32'd0, ref_mem[idx]};
    e.rdata = 32'd0; e.writes = 0; e.widx = idx;
    if (e.err) begin
      e.lat = 1;
    end else if (!we) begin
      v = (w >> (8 * off)) & mask;
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
      e.rdata = v[31:0];
      e.lat   = 3;
    end else begin
      v = (w & ~(mask << (8 * off))) | ((({32'd0, wd}) & mask) << (8 * off));
      ref_mem[idx] = v[31:0];
      e.writes = 1;
      e.lat    = (size == 4) ? 2 : 3;
    end
    e.wval = ref_mem[idx];
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int   k;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      check("ready_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
    end else begin
      model(we, f3, a, wd, e);
      e.acc = cyc + 1;
      sbq.push_back(e);
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      check("busy_ready", {31'd0, req_ready}, 32'd0);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("drain_pending", sbq.size(), 32'd0);
  endtask

  // monitor: pop expected response whenever the DUT presents one
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mem_wen) begin
        wen_cnt++;
        wen_edge = cyc + 1;
      end
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_resp", {31'd0, resp_valid}, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_latency", cyc - e.acc, e.lat);
          check("write_count", wen_cnt, e.writes);
          if (e.writes != 0) check("write_edge", wen_edge - e.acc, e.lat - 1);
          check("mem_word", mem[e.widx], e.wval);
        end
        wen_cnt = 0;
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
    end
    mem[32'h100 >> 2] = 32'h80FF7F01;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);

    // directed cases
    issue(1'b0, 3'b000, 32'h102, 32'd0);          // LB  -> FFFFFFFF
    issue(1'b0, 3'b100, 32'h103, 32'd0);          // LBU -> 00000080
    issue(1'b1, 3'b010, 32'h100, 32'h11223344);   // SW
    issue(1'b1, 3'b000, 32'h101, 32'h000000AB);   // SB  -> 1122AB44
    issue(1'b1, 3'b010, 32'h200, 32'hDEADBEEF);   // SW
    issue(1'b0, 3'b001, 32'h202, 32'd0);          // LH  -> FFFFDEAD
    issue(1'b0, 3'b001, 32'h101, 32'd0);          // misaligned LH
    issue(1'b0, 3'b111, 32'h100, 32'd0);          // illegal funct3
    issue(1'b1, 3'b100, 32'h200, 32'h12345678);   // store with funct3[2]
    drain();

    // reset while the sub-word store sits in RD
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h300; req_wdata = 32'h0000CAFE;
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check("midrst_mem", mem[32'h300 >> 2], ref_mem[32'h300 >> 2]);
    check("midrst_wen", wen_cnt, 32'd0);

    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      issue(1'($urandom), 3'($urandom), $urandom_range(0, 32'h3FF), $urandom);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Load/store sequencer between the CPU memory stage and the data port of the shared word-wide memory. It turns byte, halfword and word loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses, with sign/zero extension on loads and read-modify-write for sub-word stores. This is needed because the memory array writes only whole words. The block owns the memory data port (`addr_d`/`wen`/`wdata`/`rdata`) exclusively; the instruction port is untouched.

## Interface
Parameters:
- `AWIDTH`, default 16: byte-address width decoded by the memory; `mem_addr` bits above it are passed through unchanged.

Ports (width `WORD_LEN` = 32):
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: CPU access request.
- `req_ready`  out  1: block idle, so it accepts the request this cycle.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_funct3`  in  3: RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data, right-aligned.
- `resp_valid`  out  1: one-cycle completion pulse.
- `resp_err`  out  1: qualifies `resp_valid`; access rejected.
- `resp_rdata`  out  32: extended load result; 0 for stores and errors.
- `mem_addr`  out  32: to memory `addr_d`.
- `mem_wen`  out  1: to memory `wen`.
- `mem_wdata`  out  32: to memory `wdata`.
- `mem_rdata`  in  32: from memory `rdata`. Read data is valid the cycle after the address is sampled.

## Operation
- States: `IDLE`, `RD`, `DATA`, `WR`, `RESP`.
- `IDLE`:
  - `req_ready`=1.
  - On `req_valid`: latch `req_we`/`req_funct3`/`req_addr`/`req_wdata`.
  - Next state:
    - Error → `RESP` with err.
    - Load → `RD`.
    - Word store → `WR`.
    - Sub-word store → `RD`.
- `RD`: `mem_addr`=latched address, `mem_wen`=0 → `DATA`.
- `DATA`: `mem_rdata` valid.
  - Load: extract the lane, extend, register into `resp_rdata` → `RESP`.
  - Sub-word store: drive the merged word, `mem_wen`=1 in this same cycle → `RESP`. `DATA` doubles as the write cycle.
- `WR`: word store only; `mem_wen`=1, `mem_wdata`=`req_wdata` → `RESP`.
- `RESP`: `resp_valid`=1 for exactly one cycle → `IDLE`.
- Lanes are little-endian.
  - Byte n = `word[8n+7:8n]`, where n=`addr[1:0]`.
  - Halfword = `word[16*addr[1]+15:16*addr[1]]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Store merge replaces only the addressed lane with the low 8/16 bits of `req_wdata`; other bytes keep `mem_rdata`.
- Errors (`resp_err`=1, no memory write):
  - funct3 011/110/111.
  - Stores with funct3 bit 2 set.
  - Misalignment (see Configuration).
- `mem_wen` is asserted only in `WR`, and in `DATA` for stores. `mem_wen`/`mem_addr`/`mem_wdata` are decoded from the state registers.
- Requests arriving while not `IDLE` are not accepted. The CPU holds `req_valid` and its fields until `req_ready`.

## Timing
- Request accepted at edge T:
  - Load: `resp_valid` at T+3.
  - Sub-word store: memory written at edge T+2, `resp_valid` at T+3.
  - Word store: memory written at edge T+1, `resp_valid` at T+2.
  - Error: `resp_valid`+`resp_err` at T+1.
- `req_ready` returns high in the cycle after `RESP`. Back-to-back throughput: one access per 3–4 cycles.
- Reset values: state `IDLE`, so `req_ready`=1. `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_wen`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-operation:
  - The access is abandoned and no response is issued.
  - If reset is high during `RD`, no write occurs.
  - If reset is high during a cycle with `mem_wen`=1, that write still lands at the same edge, because the memory has no reset.
- Load-after-store to the same word sees the new data: the store completes before `req_ready` rises.

## Configuration
- `MISALIGN_TRAP_EN` defined: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0, returns `resp_err` at T+1 with no memory access.
- Undefined: the offending low address bits are forced to 0 before lane selection, and the access proceeds aligned.
- Illegal funct3 always errors, independent of the macro.

## Structure
- Add to `consts.vh`:
  - funct3 constants `LSU_B`/`LSU_H`/`LSU_W`/`LSU_BU`/`LSU_HU`.
  - FSM state encodings (3-bit).
- Existing `WORD_LEN` is reused.
- One combinational sub-module, `dmem_lane_align`, implements both directions:
  - Load path: word, addr[1:0], funct3 → extended data.
  - Store path: old word, store data, addr[1:0], funct3 → merged word.

## Test plan
- LB at 0x102, memory word 0x80FF7F01 → `resp_rdata`=0xFFFFFF7F? No: byte 2 = 0xFF → 0xFFFFFFFF. LBU at 0x103 → 0x00000080. Both with `resp_valid` at T+3.
- SB 0x000000AB to 0x101 over word 0x11223344 → memory word 0x1122AB44 after edge T+2, `mem_wen` high exactly one cycle.
- SW 0xDEADBEEF to 0x200, then LH at 0x202 → 0xFFFFDEAD. Check the store `resp_valid` at T+2 and that `req_ready` is low while busy.
- LH at 0x101 with `MISALIGN_TRAP_EN` → `resp_err`=1 at T+1, `mem_wen` never asserted. Without the macro → data from the halfword at 0x100.
- funct3=111 load → `resp_err` at T+1. SBU-like store (we=1, funct3=100) → `resp_err`, memory unchanged.
- SH issued, `rst` pulsed during `RD` → memory unchanged, no `resp_valid`, `req_ready`=1 the cycle after reset.
